// File: rtl/life_gen_scheduler_if.sv
// life_gen_scheduler_if: control and status bundle between the frame scheduler
// (master) and its environment: sync counters, run/step control, the
// update-engine handshake and the memory-port grants.
interface life_gen_scheduler_if #(
    parameter int GEN_W = 16
);
    logic [9:0]       hpos;
    logic [9:0]       vpos;
    logic             run;
    logic             step;
    logic             upd_done;
    logic             upd_start;
    logic             upd_grant;
    logic             disp_grant;
    logic             frame_tick;
    logic             gen_tick;
    logic [GEN_W-1:0] gen_count;
    logic             overrun;
    logic [1:0]       dbg_state;
    logic             dbg_late;

    modport master (
        input  hpos, vpos, run, step, upd_done,
        output upd_start, upd_grant, disp_grant, frame_tick, gen_tick,
               gen_count, overrun, dbg_state, dbg_late
    );

    modport slave (
        output hpos, vpos, run, step, upd_done,
        input  upd_start, upd_grant, disp_grant, frame_tick, gen_tick,
               gen_count, overrun, dbg_state, dbg_late
    );
endinterface

// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler: shares the cell-memory port between the VGA display
// reader and the Game-of-Life update engine. Frames are divided down to a
// generation rate; in the chosen frame's vertical blank the port is handed to
// the update engine (start/done handshake) and then returned to the display.
//
// Handshake: upd_start is a one-cycle pulse issued as the grant is raised;
// the engine answers with a one-cycle upd_done pulse, which is only honoured
// while the update is in flight (UPDATE state). The grant drops the cycle
// after upd_done.
//
// Optional macro LIFE_SCHED_OVERRUN_GUARD_EN: when defined, an update still
// running at the end of vertical blank is aborted and the sticky overrun flag
// is raised. When undefined, the update keeps the port until upd_done and
// overrun reads 0; dbg_late then shows that the update ran past its window.
module life_gen_scheduler #(
    parameter int HTOTAL         = 799,
    parameter int VTOTAL         = 524,
    parameter int VIS_LINES      = 480,
    parameter int FRAMES_PER_GEN = 8,
    parameter int GEN_W          = 16
) (
    input logic                 clk,
    input logic                 reset,
    life_gen_scheduler_if.master bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_GEN - 1);
    localparam logic [9:0] H_LAST     = 10'(HTOTAL);
    localparam logic [9:0] V_BLANK    = 10'(VIS_LINES - 1);
    localparam logic [9:0] V_LAST     = 10'(VTOTAL);

    logic [1:0]       state_q, state_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             step_pend_q, step_pend_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic             upd_start_q, upd_start_d;
    logic             grant_q, grant_d;
    logic             disp_q;
    logic             frame_tick_q;
    logic             gen_tick_q, gen_tick_d;
    logic             late_q, late_d;

    logic vb_entry;
    logic vb_exit;
    logic due;
    logic fire;

    assign vb_entry = (bus.hpos == H_LAST) && (bus.vpos == V_BLANK);
    assign vb_exit  = (bus.hpos == H_LAST) && (bus.vpos == V_LAST);
    assign due      = bus.run && (frame_cnt_q == FRAME_LAST);
    // An update is launched only from IDLE at blanking entry.
    assign fire     = (state_q == S_IDLE) && vb_entry && (due || step_pend_q);

`ifdef LIFE_SCHED_OVERRUN_GUARD_EN
    logic overrun_q, overrun_d;
`endif

    // Next-state logic: frame divider, step latch, FSM and generation counter.
    always_comb begin
        state_d     = state_q;
        gen_count_d = gen_count_q;
        gen_tick_d  = 1'b0;
        upd_start_d = fire;
`ifdef LIFE_SCHED_OVERRUN_GUARD_EN
        overrun_d   = overrun_q;
`endif
        frame_cnt_d = frame_cnt_q;
        if (vb_entry) begin
            frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
        end

        // A step while paused is remembered until the update it requests starts.
        step_pend_d = (step_pend_q && !fire) || (bus.step && !bus.run);

        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (bus.upd_done) begin
                    state_d     = S_IDLE;
                    gen_count_d = gen_count_q + GEN_W'(1);
                    gen_tick_d  = 1'b1;
                end
`ifdef LIFE_SCHED_OVERRUN_GUARD_EN
                else if (vb_exit) begin
                    state_d   = S_IDLE;
                    overrun_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        grant_d = (state_d != S_IDLE);
        // Update still holding the port after blanking ended (only reachable
        // when the guard is not built in).
        late_d  = (state_d == S_UPDATE) && (late_q || (vb_exit && !bus.upd_done));
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= 8'd0;
            step_pend_q  <= 1'b0;
            gen_count_q  <= '0;
            upd_start_q  <= 1'b0;
            grant_q      <= 1'b0;
            disp_q       <= 1'b1;
            frame_tick_q <= 1'b0;
            gen_tick_q   <= 1'b0;
            late_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            step_pend_q  <= step_pend_d;
            gen_count_q  <= gen_count_d;
            upd_start_q  <= upd_start_d;
            grant_q      <= grant_d;
            disp_q       <= !grant_d;
            frame_tick_q <= vb_entry;
            gen_tick_q   <= gen_tick_d;
            late_q       <= late_d;
        end
    end

`ifdef LIFE_SCHED_OVERRUN_GUARD_EN
    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.upd_start  = upd_start_q;
    assign bus.upd_grant  = grant_q;
    assign bus.disp_grant = disp_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.gen_tick   = gen_tick_q;
    assign bus.gen_count  = gen_count_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_late   = late_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// tb_life_gen_scheduler: drives a shrunken VGA raster (10 x 12 positions) and a
// model update engine, and compares every output on every cycle with a
// behavioural model of the scheduling rules, plus scenario tables and
// hand-written corner sequences.
module tb_life_gen_scheduler;

    localparam int HT  = 9;
    localparam int VT  = 11;
    localparam int VIS = 8;
    localparam int FPG = 2;
    localparam int GW  = 4;

`ifdef LIFE_SCHED_OVERRUN_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk;
    logic reset;

    life_gen_scheduler_if #(.GEN_W(GW)) bus ();

    life_gen_scheduler #(
        .HTOTAL(HT), .VTOTAL(VT), .VIS_LINES(VIS),
        .FRAMES_PER_GEN(FPG), .GEN_W(GW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench control
    int h, v, cyc, eng_due, eng_delay;
    bit rst_r, run_r, step_r, spur_r;
    int n_starts, n_gticks;
    int n_checks, n_pass;

    // Behavioural model: who owns the port, how long it has owned it, frames
    // counted toward the next generation, pending step, completed generations.
    bit m_owned, m_pend, m_ovr, m_start, m_ftick, m_gtick;
    int m_age, m_frame, m_gens;

    typedef struct {
        bit run;
        int step_frame;
        int step_off;
        int delay;
        int frames;
        int exp_gens;
        int exp_ovr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit rst, input bit vbe, input bit vbx,
                              input bit run, input bit stp, input bit done);
        bit fire;
        if (rst) begin
            m_owned = 0; m_age = 0; m_frame = 0; m_pend = 0; m_gens = 0;
            m_ovr = 0; m_start = 0; m_ftick = 0; m_gtick = 0;
        end else begin
            fire    = !m_owned && vbe && ((run && m_frame == FPG - 1) || m_pend);
            m_ftick = vbe;
            m_start = fire;
            m_gtick = 0;
            if (vbe) m_frame = (m_frame + 1) % FPG;
            if (m_owned) begin
                if (m_age >= 1 && done) begin
                    m_owned = 0;
                    m_gens  = (m_gens + 1) % (1 << GW);
                    m_gtick = 1;
                end else if (GUARD && m_age >= 1 && vbx) begin
                    m_owned = 0;
                    m_ovr   = 1;
                end
                m_age++;
            end
            if (fire) begin
                m_pend  = 0;
                m_owned = 1;
                m_age   = 0;
            end
            if (stp && !run) m_pend = 1;
        end
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge, compare.
    task automatic tick();
        reset        = rst_r;
        bus.hpos     = 10'(h);
        bus.vpos     = 10'(v);
        bus.run      = run_r;
        bus.step     = step_r;
        bus.upd_done = (cyc == eng_due) || spur_r;
        model_step(rst_r, (h == HT && v == VIS - 1), (h == HT && v == VT),
                   run_r, step_r, bus.upd_done);
        @(posedge clk);
        #1;
        cyc++;
        chk("upd_start",  bus.upd_start,  m_start);
        chk("upd_grant",  bus.upd_grant,  m_owned);
        chk("disp_grant", bus.disp_grant, !m_owned);
        chk("frame_tick", bus.frame_tick, m_ftick);
        chk("gen_tick",   bus.gen_tick,   m_gtick);
        chk("gen_count",  bus.gen_count,  m_gens);
        chk("overrun",    bus.overrun,    m_ovr);
        if (bus.upd_start) n_starts++;
        if (bus.gen_tick)  n_gticks++;
        if (rst_r) eng_due = -1;
        else if (m_start) eng_due = cyc + eng_delay;
        h++;
        if (h > HT) begin
            h = 0;
            v++;
            if (v > VT) v = 0;
        end
        step_r = 0;
        spur_r = 0;
    endtask

    task automatic do_reset();
        rst_r = 1;
        tick();
        tick();
        rst_r    = 0;
        h        = 0;
        v        = 0;
        eng_due  = -1;
        n_starts = 0;
        n_gticks = 0;
    endtask

    task automatic run_frames(input int nf, input int sf, input int so);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < (HT + 1) * (VT + 1); k++) begin
                if (f == sf && k == so) step_r = 1;
                tick();
            end
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; eng_due = -1; eng_delay = 1;
        h = 0; v = 0; rst_r = 1; run_r = 0; step_r = 0; spur_r = 0;
        n_starts = 0; n_gticks = 0;

        // run, step frame, step offset, engine delay, frames, gens, overrun
        vecs[0] = '{1'b1, -1,  0, 10, 8, 4, 0};   // free run
        vecs[1] = '{1'b0,  2, 30,  5, 6, 1, 0};   // paused, one step mid-frame
        vecs[2] = '{1'b1, -1,  0, 39, 4, 2, 0};   // done coincident with vb_exit
        vecs[3] = '{1'b0, -1,  0,  5, 5, 0, 0};   // paused, no step
        vecs[4] = '{1'b1, -1,  0,  1, 6, 3, 0};   // fastest engine
        vecs[5] = '{1'b1,  0, 30,  5, 2, 1, 0};   // step ignored while running
        vecs[6] = '{1'b0,  0, 79,  5, 2, 1, 0};   // step on non-triggering vb_entry

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_r     = vecs[i].run;
            eng_delay = vecs[i].delay;
            run_frames(vecs[i].frames, vecs[i].step_frame, vecs[i].step_off);
            chk("vec_gen_count", bus.gen_count, vecs[i].exp_gens);
            chk("vec_starts",    n_starts,      vecs[i].exp_gens);
            chk("vec_overrun",   bus.overrun,   vecs[i].exp_ovr);
        end

        // Spurious upd_done while idle is ignored
        do_reset();
        run_r  = 0;
        spur_r = 1;
        tick();
        chk("spur_gen_tick",  bus.gen_tick,  0);
        chk("spur_gen_count", bus.gen_count, 0);

        // Overrun: start at 200, vb_exit at 239, late done at 260
        do_reset();
        run_r     = 1;
        eng_delay = 60;
        for (int i = 0; i < 270; i++) begin
            tick();
            if (i == 239) begin
                chk("ovr_grant_at_exit",   bus.upd_grant, GUARD ? 0 : 1);
                chk("ovr_flag_at_exit",    bus.overrun,   GUARD ? 1 : 0);
                chk("ovr_count_at_exit",   bus.gen_count, 0);
            end
            if (i == 260) begin
                chk("ovr_count_after_done", bus.gen_count, GUARD ? 0 : 1);
                chk("ovr_grant_after_done", bus.upd_grant, 0);
                chk("ovr_disp_after_done",  bus.disp_grant, 1);
            end
        end

        // Reset asserted mid-UPDATE
        do_reset();
        run_r     = 1;
        eng_delay = 5;
        run_frames(4, -1, 0);
        chk("rst_pre_count", bus.gen_count, 2);
        eng_delay = 1000;
        run_frames(1, -1, 0);
        for (int k = 0; k <= 85; k++) tick();
        chk("rst_pre_grant", bus.upd_grant, 1);
        rst_r = 1;
        tick();
        rst_r = 0;
        chk("rst_grant",    bus.upd_grant,  0);
        chk("rst_disp",     bus.disp_grant, 1);
        chk("rst_count",    bus.gen_count,  0);
        chk("rst_gen_tick", bus.gen_tick,   0);
        n_gticks = 0;
        for (int k = 0; k < 20; k++) tick();
        chk("rst_no_late_tick", n_gticks, 0);

        // Generation counter wraps after 16 generations
        do_reset();
        run_r     = 1;
        eng_delay = 1;
        run_frames(32, -1, 0);
        chk("wrap_gen_count", bus.gen_count, 0);
        chk("wrap_gen_ticks", n_gticks, 16);

        // Randomized run/step/engine timing against the model
        do_reset();
        for (int f = 0; f < 40; f++) begin
            run_r     = ($urandom_range(0, 3) != 0);
            eng_delay = $urandom_range(1, 70);
            for (int k = 0; k < (HT + 1) * (VT + 1); k++) begin
                if ($urandom_range(0, 199) == 0) step_r = 1;
                if ($urandom_range(0, 149) == 0) spur_r = 1;
                if ($urandom_range(0, 499) == 0) run_r = !run_r;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
